// File: rtl/conv_encoder_sys_if.sv
// Stream interface of the rate-1/2 K=3 convolutional encoder.
// Input side:  in_bit / in_valid / in_ready (one data bit per handshake).
// Output side: encoded_bits / out_valid / out_ready plus frame markers
//              out_first / out_last. encoded_bits[1] = G0 parity, [0] = G1 parity.
// slave  : the encoder (consumes bits, produces symbols).
// master : the environment around it (produces bits, consumes symbols).
interface conv_encoder_sys_if;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] encoded_bits;
   logic       out_valid;
   logic       out_ready;
   logic       out_first;
   logic       out_last;

   modport slave (
      input  in_bit, in_valid, out_ready,
      output in_ready, encoded_bits, out_valid, out_first, out_last
   );

   modport master (
      output in_bit, in_valid, out_ready,
      input  in_ready, encoded_bits, out_valid, out_first, out_last
   );
endinterface

// File: rtl/conv_encoder_sys.sv
// Rate-1/2, K=3 convolutional encoder with fixed-length frames and 2 zero
// tail bits per frame, so every frame ends in trellis state 00.
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-high reset
//   bus         - conv_encoder_sys_if.slave stream (bit in, symbol out)
//   frame_count - completed frames, wraps 255 -> 0
module conv_encoder_sys #(
   parameter int unsigned FRAME_LEN = 13,
   parameter logic [2:0]  G0        = 3'b111,
   parameter logic [2:0]  G1        = 3'b101
) (
   input  logic               clk,
   input  logic               rst,
   conv_encoder_sys_if.slave  bus,
   output logic [7:0]         frame_count
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] FRAME_LEN_W = CNT_W'(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sr_q, sr_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             tail_cnt_q, tail_cnt_d;
   logic [1:0]       enc_q, enc_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] frame_count_q, frame_count_d;

   logic slot_free_c;
   logic in_ready_c;
   logic accept_c;

   // Parity of {current, previous, one-before} against a generator.
   function automatic logic [1:0] encode(input logic b, input logic [1:0] sr);
      logic [2:0] reg3;
      reg3 = {b, sr[0], sr[1]};
      return {^(reg3 & G0), ^(reg3 & G1)};
   endfunction

   // Output slot can take a new symbol when empty or being retired now.
   assign slot_free_c = !valid_q || bus.out_ready;
   assign in_ready_c  = slot_free_c && ((state_q == IDLE) || (state_q == DATA));
   assign accept_c    = in_ready_c && bus.in_valid;

   // Next-state and output-register logic.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      bit_cnt_d     = bit_cnt_q;
      tail_cnt_d    = tail_cnt_q;
      enc_d         = enc_q;
      valid_d       = valid_q;
      first_d       = first_q;
      last_d        = last_q;
      frame_count_d = frame_count_q;

      // Retire the held symbol; a load below overrides this.
      if (slot_free_c) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               enc_d      = encode(bus.in_bit, sr_q);
               sr_d       = {sr_q[0], bus.in_bit};
               valid_d    = 1'b1;
               first_d    = 1'b1;
               last_d     = 1'b0;
               bit_cnt_d  = CNT_W'(1);
               tail_cnt_d = 1'b0;
               state_d    = (FRAME_LEN == 1) ? TAIL : DATA;
            end
         end
         DATA: begin
            if (accept_c) begin
               enc_d     = encode(bus.in_bit, sr_q);
               sr_d      = {sr_q[0], bus.in_bit};
               valid_d   = 1'b1;
               first_d   = 1'b0;
               last_d    = 1'b0;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q + CNT_W'(1) == FRAME_LEN_W) begin
                  tail_cnt_d = 1'b0;
                  state_d    = TAIL;
               end
            end
         end
         TAIL: begin
            // Zero tail flushes sr back to 00 without an explicit clear.
            if (slot_free_c) begin
               enc_d      = encode(1'b0, sr_q);
               sr_d       = {sr_q[0], 1'b0};
               valid_d    = 1'b1;
               first_d    = 1'b0;
               last_d     = tail_cnt_q;
               tail_cnt_d = 1'b1;
               if (tail_cnt_q) begin
                  frame_count_d = frame_count_q + CNT_W'(1);
                  bit_cnt_d     = '0;
                  state_d       = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sr_q          <= 2'b00;
         bit_cnt_q     <= '0;
         tail_cnt_q    <= 1'b0;
         enc_q         <= 2'b00;
         valid_q       <= 1'b0;
         first_q       <= 1'b0;
         last_q        <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         bit_cnt_q     <= bit_cnt_d;
         tail_cnt_q    <= tail_cnt_d;
         enc_q         <= enc_d;
         valid_q       <= valid_d;
         first_q       <= first_d;
         last_q        <= last_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.in_ready     = in_ready_c;
   assign bus.encoded_bits = enc_q;
   assign bus.out_valid    = valid_q;
   assign bus.out_first    = first_q;
   assign bus.out_last     = last_q;
   assign frame_count      = frame_count_q;

endmodule
